johnson_decoder: RTL
====================

# johnson_decoder

Receive-side checker for the 3-bit-class Johnson (twisted-ring) counters used throughout the design. The block samples a Johnson-coded word, decodes it to a binary state index, and flags illegal codes. It tracks sequence continuity against the expected next state and runs a lock state machine that reports when the incoming stream is a clean, stepping Johnson sequence. It sits downstream of any Johnson counter whose state must be consumed as a binary index or monitored for corruption.

## Interface
- N, default 3: Johnson code width. Legal states are 2N; N ≥ 2.
- LOCK_CNT, default 3: consecutive legal, in-sequence samples required to lock; range 1..15.
- IW, default $clog2(2N): index width. Derived; do not override.
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- in_valid  input  1  jc_in is sampled this cycle
- jc_in  input  N  Johnson-coded word
- out_valid  output  1  registered result valid, one cycle after in_valid
- idx_out  output  IW  decoded state index 0..2N-1; 0 when the code is illegal
- illegal  output  1  sampled code is not one of the 2N legal codes
- seq_err  output  1  legal code, reference exists, index differs from expected
- locked  output  1  lock FSM is in LOCKED
- err_count  output  8  saturating error counter; present only with JDEC_ERR_CNT_EN

## Operation
- Sequence definition: the next state is {~q[0], q[N-1:1]}, starting from all-zeros. For N=3: 000→100→110→111→011→001→000, which gives indices 0..5.
- Legal code: ones contiguous from the MSB (1..10..0) or contiguous from the LSB (0..01..1). All-zeros and all-ones are legal.
- Decode: idx = popcount when q[0]=0; idx = 2N − popcount when q[0]=1.
- Reference: after any legal sample, ref_idx ← idx and have_ref ← 1. expected = (ref_idx+1) mod 2N, wrapping 2N−1→0.
- Illegal sample: the reference is left unchanged, and the next legal sample is compared against it. have_ref is cleared only by reset or an unlock.
- in_valid=0: no state change. Gaps of any length do not break the sequence.
- Lock FSM states: HUNT, LOCKED.
  - HUNT: a legal sample with no reference or in sequence increments run_cnt. A legal out-of-sequence sample sets run_cnt to 1 and re-bases the reference. An illegal sample sets run_cnt to 0. When run_cnt reaches LOCK_CNT, go to LOCKED.
  - LOCKED: an illegal sample or seq_err goes to HUNT, with run_cnt=0 and have_ref=0.
- seq_err can be flagged in either state. illegal and seq_err are never both 1.
- Reset values: out_valid=0, idx_out=0, illegal=0, seq_err=0, locked=0, err_count=0. The FSM is in HUNT, run_cnt=0, have_ref=0.
- Reset during a stream: everything returns to reset values on the next edge. An in_valid asserted in the reset cycle is discarded.

## Timing
- Latency is 1 cycle. Sample at edge k produces out_valid, idx_out, illegal and seq_err valid after edge k. They hold for one cycle only, and the flags are 0 whenever out_valid=0.
- locked updates on the same edge as the result for the sample that caused the transition. It is high alongside the LOCK_CNT-th good result and low alongside the offending result.
- Throughput is one sample per cycle. There is no backpressure.

## Configuration
- JDEC_ERR_CNT_EN defined:
  - The err_count port exists.
  - It increments by 1 on every out_valid cycle with illegal or seq_err set, in any FSM state.
  - It saturates at 255 and clears only on reset.
- JDEC_ERR_CNT_EN undefined: the port and counter logic are absent. All other behaviour is identical.

## Structure
- jdec_pkg contains:
  - the jdec_state_e enum {HUNT, LOCKED};
  - an 8-bit ERR_CNT_MAX constant;
  - functions jc_legal(code, N) and jc_index(code, N).
- Sub-module johnson_decode_comb: purely combinational jc_in → {legal, idx}. The top level holds the registers, reference tracking, FSM and counter.

## Test plan
- Reset, then feed 000,100,110 with in_valid every cycle (N=3, LOCK_CNT=3) → idx_out 0,1,2; locked rises alongside idx 2; no flags raised.
- While locked, step 111,011,001,000,100 → idx 3,4,5,0,1; wrap 5→0 is clean; locked stays 1.
- While locked with last idx 1, feed 010 → illegal=1, idx_out=0, locked=0, err_count=1. Then 000,100,110 → relock alongside the third result.
- While locked with last idx 2, feed 011 (idx 4) → seq_err=1, locked=0, err_count+1.
- Valid 100, then 5 idle cycles, then 110 → no seq_err; out_valid low during the gap.
- Mid-stream reset asserted for one cycle with in_valid=1 → all outputs 0 next cycle. The sample is discarded, and the first post-reset sample is treated as having no reference.

Source files
------------

// File: rtl/jdec_pkg.sv
// Shared types, constants and Johnson-code helper functions for the johnson_decoder slice.
// Optional feature macro used by the top: JDEC_ERR_CNT_EN.
package jdec_pkg;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } jdec_state_e;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;
    localparam int         JC_MAX_W    = 32;

    // A legal Johnson word has at most one 0/1 boundary between adjacent bits (0*1* or 1*0*).
    function automatic logic jc_legal(input logic [JC_MAX_W-1:0] code, input int n);
        int trans;
        trans = 0;
        for (int i = 0; i < JC_MAX_W - 1; i++) begin
            if ((i < n - 1) && (code[i] != code[i+1])) begin
                trans = trans + 1;
            end else begin
                trans = trans;
            end
        end
        return (trans <= 1);
    endfunction

    // Rising half of the ring counts ones from the MSB; falling half counts down from 2N.
    function automatic int jc_index(input logic [JC_MAX_W-1:0] code, input int n);
        int ones;
        ones = 0;
        for (int i = 0; i < JC_MAX_W; i++) begin
            if ((i < n) && code[i]) begin
                ones = ones + 1;
            end else begin
                ones = ones;
            end
        end
        if (code[0]) begin
            return (2 * n) - ones;
        end else begin
            return ones;
        end
    endfunction

endpackage

// File: rtl/johnson_decode_comb.sv
// Purely combinational Johnson word -> {legal, binary index}; index forced to 0 on illegal codes.
module johnson_decode_comb
    import jdec_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = $clog2(2 * N)
) (
    input  logic [N-1:0]  jc_in,
    output logic          legal,
    output logic [IW-1:0] idx
);

    logic [JC_MAX_W-1:0] code_s;
    int                  idx_full_s;

    assign code_s     = JC_MAX_W'(jc_in);
    assign idx_full_s = jc_index(code_s, N);

    // Classify the word and gate the index with legality.
    always_comb begin
        legal = jc_legal(code_s, N);
        if (legal) begin
            idx = IW'(idx_full_s);
        end else begin
            idx = {IW{1'b0}};
        end
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code receive checker: decode, illegal/sequence flags, lock FSM.
// Define JDEC_ERR_CNT_EN to add the saturating err_count port.
module johnson_decoder
    import jdec_pkg::*;
#(
    parameter int N        = 3,
    parameter int LOCK_CNT = 3,
    parameter int IW       = $clog2(2 * N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [N-1:0]  jc_in,
    output logic          out_valid,
    output logic [IW-1:0] idx_out,
    output logic          illegal,
    output logic          seq_err,
    output logic          locked
`ifdef JDEC_ERR_CNT_EN
    ,
    output logic [7:0]    err_count
`endif
);

    localparam logic [IW-1:0] LAST_IDX = IW'(2 * N - 1);
    localparam logic [3:0]    LOCK_TGT = 4'(LOCK_CNT);

    logic          legal_s;
    logic [IW-1:0] idx_s;
    logic [IW-1:0] expected_s;
    logic          in_seq_s;
    logic          illegal_s;
    logic          seq_err_s;

    jdec_state_e   state_r;
    jdec_state_e   state_nxt_s;
    logic [3:0]    run_cnt_r;
    logic [3:0]    run_cnt_nxt_s;
    logic [3:0]    run_inc_s;
    logic          have_ref_r;
    logic          have_ref_nxt_s;
    logic [IW-1:0] ref_idx_r;
    logic [IW-1:0] ref_idx_nxt_s;

    johnson_decode_comb #(
        .N  (N),
        .IW (IW)
    ) u_decode (
        .jc_in (jc_in),
        .legal (legal_s),
        .idx   (idx_s)
    );

    // Expected successor of the reference index, and the per-sample flags.
    always_comb begin
        if (ref_idx_r == LAST_IDX) begin
            expected_s = {IW{1'b0}};
        end else begin
            expected_s = ref_idx_r + IW'(1);
        end
        in_seq_s  = have_ref_r && (idx_s == expected_s);
        illegal_s = in_valid && !legal_s;
        seq_err_s = in_valid && legal_s && have_ref_r && !in_seq_s;
        run_inc_s = run_cnt_r + 4'd1;
    end

    // State register: FSM, run counter and reference tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= HUNT;
            run_cnt_r  <= 4'd0;
            have_ref_r <= 1'b0;
            ref_idx_r  <= {IW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            run_cnt_r  <= run_cnt_nxt_s;
            have_ref_r <= have_ref_nxt_s;
            ref_idx_r  <= ref_idx_nxt_s;
        end
    end

    // Next-state logic; idle cycles leave everything untouched so gaps never break a sequence.
    always_comb begin
        state_nxt_s    = state_r;
        run_cnt_nxt_s  = run_cnt_r;
        have_ref_nxt_s = have_ref_r;
        ref_idx_nxt_s  = ref_idx_r;
        if (in_valid) begin
            case (state_r)
                HUNT: begin
                    if (!legal_s) begin
                        run_cnt_nxt_s = 4'd0;
                    end else if (!have_ref_r || in_seq_s) begin
                        run_cnt_nxt_s  = run_inc_s;
                        have_ref_nxt_s = 1'b1;
                        ref_idx_nxt_s  = idx_s;
                        if (run_inc_s >= LOCK_TGT) begin
                            state_nxt_s = LOCKED;
                        end else begin
                            state_nxt_s = HUNT;
                        end
                    end else begin
                        run_cnt_nxt_s  = 4'd1;
                        have_ref_nxt_s = 1'b1;
                        ref_idx_nxt_s  = idx_s;
                        if (LOCK_TGT <= 4'd1) begin
                            state_nxt_s = LOCKED;
                        end else begin
                            state_nxt_s = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (!legal_s || seq_err_s) begin
                        state_nxt_s    = HUNT;
                        run_cnt_nxt_s  = 4'd0;
                        have_ref_nxt_s = 1'b0;
                    end else begin
                        have_ref_nxt_s = 1'b1;
                        ref_idx_nxt_s  = idx_s;
                    end
                end
                default: begin
                    state_nxt_s    = HUNT;
                    run_cnt_nxt_s  = 4'd0;
                    have_ref_nxt_s = 1'b0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Result registers: one-cycle pulse per accepted sample, flags zero otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            idx_out   <= {IW{1'b0}};
            illegal   <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            idx_out   <= in_valid ? idx_s : {IW{1'b0}};
            illegal   <= illegal_s;
            seq_err   <= seq_err_s;
        end
    end

    assign locked = (state_r == LOCKED);

`ifdef JDEC_ERR_CNT_EN
    logic [7:0] err_cnt_r;
    logic [7:0] err_cnt_nxt_s;

    // Saturating error count, bumped on the same edge the flag is presented.
    always_comb begin
        if ((illegal_s || seq_err_s) && (err_cnt_r != ERR_CNT_MAX)) begin
            err_cnt_nxt_s = err_cnt_r + 8'd1;
        end else begin
            err_cnt_nxt_s = err_cnt_r;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_r <= 8'd0;
        end else begin
            err_cnt_r <= err_cnt_nxt_s;
        end
    end

    assign err_count = err_cnt_r;
`endif

endmodule
